aes128_decrypt_core: RTL
========================

// Module: aes128_decrypt_core
// PURPOSE
//  Iterative AES-128 inverse cipher (FIPS-197 InvCipher): ciphertext + cipher key in, plaintext out.
//  Receive-side counterpart of the AES-128 encryption datapath; same byte/state ordering and key schedule.
//  One round per clock, with the round keys regenerated in reverse order on the fly (no 11-key storage).
//  Optional last-key cache skips forward key expansion when consecutive blocks share a key.
// PARAMETERS
//  KEY_CACHE  1  1: cache the last key and its rk10; 0: always run forward expansion
// PORTS
//  clk         in   1    single clock, rising edge
//  reset       in   1    synchronous, active-high; clears all state
//  in_valid    in   1    ciphertext/key present
//  in_ready    out  1    core idle, will accept
//  ciphertext  in   128  [127:120] = byte 0
//  key         in   128  cipher key, [127:120] = byte 0
//  out_valid   out  1    plaintext valid; held until out_ready
//  out_ready   in   1    downstream accepts plaintext
//  plaintext   out  128  [127:120] = byte 0
// BEHAVIOUR
//  Ordering: byte i maps to state row i%4, col i/4 (column-major), same as the encryption path.
//  Reset: in_ready=0 in the reset cycle, then 1; out_valid=0; plaintext=0; FSM=IDLE; cache invalid.
//   Reset mid-operation aborts the block; no output is produced for it.
//  FSM IDLE -> KEYEXP -> DEC -> DONE -> IDLE.
//  IDLE: in_ready=1. Accept on in_valid&in_ready: state<=ciphertext, kreg<=key, cnt<=1.
//   KEY_CACHE=1, cache valid and key==cached_key: state<=ciphertext^rk10, kreg<=rk10, cnt<=10,
//   go to DEC (skips KEYEXP).
//  KEYEXP: one forward expansion step per cycle: w0'=w0^SubWord(RotWord(w3))^Rcon(cnt),
//   w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'. cnt counts 1..10.
//   At cnt==10: kreg<=rk10, state<=state^rk10, cache<={key,rk10} (valid), cnt stays 10, go to DEC.
//  DEC (cnt=c, 10..1): rk_{c-1} from kreg=rk_c combinationally, using Rcon(c):
//   v3=w3^w2, v2=w2^w1, v1=w1^w0, v0=w0^SubWord(RotWord(v3))^Rcon(c).
//   state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_{c-1}); InvMixColumns omitted when c==1.
//   kreg<=rk_{c-1}; cnt<=c-1; at c==1 go to DONE and load plaintext<=result.
//  DONE: out_valid=1, plaintext stable until the out_valid&out_ready edge, then IDLE (out_valid<=0).
//   in_ready=0 in DONE; no same-cycle accept.
//  Latency, acceptance edge to out_valid: 20 cycles (cache miss), 10 cycles (cache hit).
//  Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36. No intermediate values appear on outputs.
//  Arithmetic: GF(2^8) modulo x^8+x^4+x^3+x+1; InvMixColumns coefficients {0e,0b,0d,09}.
//  Datapath: 16 inverse S-box lookups + 4 forward S-box lookups per cycle, all combinational;
//   the forward S-box is shared by KEYEXP and DEC (only one state is active at a time).
//  in_valid in non-IDLE states is ignored; inputs are sampled only at the acceptance edge.
//  KEY_CACHE=0: cache logic absent, every block takes 20 cycles.
// TESTING
//  FIPS-197 C.1: key 000102..0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a
//   -> pt 00112233445566778899aabbccddeeff, out_valid exactly 20 cycles after accept.
//  FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32
//   -> pt 3243f6a8885a308d313198a2e0370734.
//  Cache hit: App.B twice with the same key -> second result correct, latency 10.
//   Then C.1 key -> miss, latency 20, correct result.
//  Backpressure: out_ready=0 for 7 cycles -> out_valid and plaintext held, in_ready=0, extra in_valid ignored.
//   One-cycle out_ready -> IDLE next cycle.
//  Reset at DEC cnt=5 -> next cycle out_valid=0, plaintext=0, in_ready=1.
//   The following C.1 block takes 20 cycles (cache cleared).
//  Random: 1000 key/ct pairs, decrypt(encrypt(pt))==pt against the encryption core / software model.

Source files
------------

// File: rtl/aes128_decrypt_core.sv
// AES-128 inverse cipher, one round per clock. Round keys are rolled back from rk10 on the fly;
// an optional one-entry cache keeps the last key's rk10 so a repeated key skips forward expansion.
module aes128_decrypt_core #(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    typedef enum logic [1:0] {StIdle, StKeyExp, StDec, StDone} fsm_e;

    localparam logic [31:0] InvMixCoef = 32'h0e0b0d09;

    fsm_e         fsm_q;
    logic [3:0]   cnt_q;
    logic [127:0] blk_q;
    logic [127:0] kreg_q;
    logic [127:0] key_q;
    logic         cache_valid_q;
    logic [127:0] cache_key_q;
    logic [127:0] cache_rk_q;
    logic         out_valid_q;
    logic [127:0] plaintext_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sbox_word;
    logic [31:0]  new_w0;
    logic [127:0] fwd_key;
    logic [127:0] rk_prev;
    logic [127:0] add_key;
    logic [127:0] dec_next;
    logic         cache_hit;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 via an addition chain (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(x3, x3);
        x12  = gf_mul(x12, x12);
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] c);
        case (c)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gf_mul(InvMixCoef[31 - 8*((j - i + 4) % 4) -: 8],
                                       s[127 - 8*(4*c + j) -: 8]);
                end
                o[127 - 8*(4*c + i) -: 8] = acc;
            end
        end
        return o;
    endfunction

    assign cache_hit = KEY_CACHE && cache_valid_q && (key == cache_key_q);

    // One forward S-box word serves both directions: w3 when expanding, w3^w2 when rolling back.
    always_comb begin
        {w0, w1, w2, w3} = kreg_q;
        sbox_word = (fsm_q == StDec) ? (w3 ^ w2) : w3;
        new_w0    = w0 ^ sub_word(rot_word(sbox_word)) ^ {rcon(cnt_q), 24'h000000};
        fwd_key   = {new_w0, w1 ^ new_w0, w2 ^ w1 ^ new_w0, w3 ^ w2 ^ w1 ^ new_w0};
        rk_prev   = {new_w0, w1 ^ w0, w2 ^ w1, w3 ^ w2};
        add_key   = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_prev;
        dec_next  = (cnt_q == 4'd1) ? add_key : inv_mix_columns(add_key);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q         <= StIdle;
            cnt_q         <= 4'd0;
            blk_q         <= '0;
            kreg_q        <= '0;
            key_q         <= '0;
            cache_valid_q <= 1'b0;
            cache_key_q   <= '0;
            cache_rk_q    <= '0;
            out_valid_q   <= 1'b0;
            plaintext_q   <= '0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (in_valid) begin
                        if (cache_hit) begin
                            blk_q  <= ciphertext ^ cache_rk_q;
                            kreg_q <= cache_rk_q;
                            cnt_q  <= 4'd10;
                            fsm_q  <= StDec;
                        end else begin
                            blk_q  <= ciphertext;
                            kreg_q <= key;
                            key_q  <= key;
                            cnt_q  <= 4'd1;
                            fsm_q  <= StKeyExp;
                        end
                    end
                end
                StKeyExp: begin
                    kreg_q <= fwd_key;
                    if (cnt_q == 4'd10) begin
                        blk_q <= blk_q ^ fwd_key;
                        fsm_q <= StDec;
                        if (KEY_CACHE) begin
                            cache_valid_q <= 1'b1;
                            cache_key_q   <= key_q;
                            cache_rk_q    <= fwd_key;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDec: begin
                    kreg_q <= rk_prev;
                    blk_q  <= dec_next;
                    cnt_q  <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        plaintext_q <= dec_next;
                        out_valid_q <= 1'b1;
                        fsm_q       <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= StIdle;
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (fsm_q == StIdle) && !reset;
    assign out_valid = out_valid_q;
    assign plaintext = plaintext_q;

endmodule
